// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encoding, the fault code values reported on fault_code,
// and the access-size encoding used by the lane selector.
package data_mem_responder_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the CPU MEM stage (master) and the data memory (slave).
// Master drives: mem_addr, mem_write_data, mem_wr, mem_sb, mem_sh, mem_lb, mem_lh.
// Slave drives : mem_read_data, ready, fault, fault_code, fault_addr, store_count.
interface data_mem_responder_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      mem_addr;
  logic [31:0]      mem_write_data;
  logic             mem_wr;
  logic             mem_sb;
  logic             mem_sh;
  logic             mem_lb;
  logic             mem_lh;
  logic [31:0]      mem_read_data;
  logic             ready;
  logic             fault;
  logic [1:0]       fault_code;
  logic [31:0]      fault_addr;
  logic [CNT_W-1:0] store_count;

  modport master (
    output mem_addr, mem_write_data, mem_wr, mem_sb, mem_sh, mem_lb, mem_lh,
    input  mem_read_data, ready, fault, fault_code, fault_addr, store_count
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_wr, mem_sb, mem_sh, mem_lb, mem_lh,
    output mem_read_data, ready, fault, fault_code, fault_addr, store_count
  );
endinterface

// File: rtl/data_mem_responder_lane_select.sv
// Combinational byte-lane decoder for a big-endian 32-bit word.
// Ports:
//   i_addr     low two address bits
//   i_wr       access is a store (selects which alignment rule applies)
//   i_sb/i_sh  store size (sb > sh > word)
//   i_lb/i_lh  load size  (lb > lh > word)
//   o_wrMask   byte lanes written; bit 3 = bits 31:24
//   o_aligned  access is naturally aligned for its size
//   o_rdShift  right shift that brings the selected load lanes to bit 0
//   o_rdSize   decoded load size
module data_mem_responder_lane_select
  import data_mem_responder_pkg::*;
(
  input  logic [1:0] i_addr,
  input  logic       i_wr,
  input  logic       i_sb,
  input  logic       i_sh,
  input  logic       i_lb,
  input  logic       i_lh,
  output logic [3:0] o_wrMask,
  output logic       o_aligned,
  output logic [4:0] o_rdShift,
  output size_t      o_rdSize
);

  size_t w_wrSize;
  logic  w_wrAligned;
  logic  w_rdAligned;

  // Decode sizes, lanes and alignment. Byte lane n sits at (3-n)*8, which
  // for a 2-bit index is simply the inverted address times eight.
  always_comb begin
    w_wrSize    = i_sb ? SZ_BYTE : (i_sh ? SZ_HALF : SZ_WORD);
    o_rdSize    = i_lb ? SZ_BYTE : (i_lh ? SZ_HALF : SZ_WORD);
    o_wrMask    = 4'b1111;
    w_wrAligned = (i_addr == 2'b00);
    w_rdAligned = (i_addr == 2'b00);
    o_rdShift   = 5'd0;

    case (w_wrSize)
      SZ_BYTE: begin
        o_wrMask    = 4'b1000 >> i_addr;
        w_wrAligned = 1'b1;
      end
      SZ_HALF: begin
        o_wrMask    = i_addr[1] ? 4'b0011 : 4'b1100;
        w_wrAligned = ~i_addr[0];
      end
      default: ;
    endcase

    case (o_rdSize)
      SZ_BYTE: begin
        o_rdShift   = {~i_addr, 3'b000};
        w_rdAligned = 1'b1;
      end
      SZ_HALF: begin
        o_rdShift   = {~i_addr[1], 4'b0000};
        w_rdAligned = ~i_addr[0];
      end
      default: ;
    endcase

    o_aligned = i_wr ? w_wrAligned : w_rdAligned;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: far end of the CPU load/store port.
// Big-endian byte-addressable word array, synchronous sub-word stores,
// combinational loads, post-reset clear, sticky fault capture and a
// saturating store counter.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    slave side of data_mem_responder_if (address/data/strobes in,
//          read data, ready, fault status and store count out)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t           r_state;
  logic [AW-1:0]    r_clearPtr;
  logic             r_ready;
  logic             r_fault;
  logic [1:0]       r_faultCode;
  logic [31:0]      r_faultAddr;
  logic [CNT_W-1:0] r_storeCount;
  logic [31:0]      r_mem [MEM_WORDS];

  logic [AW-1:0] w_wordIdx;
  logic          w_inRange;
  logic          w_access;
  logic [3:0]    w_wrMask;
  logic          w_aligned;
  logic [4:0]    w_rdShift;
  size_t         w_rdSize;
  logic [31:0]   w_wrLanes;
  logic [31:0]   w_memWord;
  logic [31:0]   w_shifted;
  logic          w_commit;
  logic          w_faultNow;

  data_mem_responder_lane_select u_laneSelect (
    .i_addr    (bus.mem_addr[1:0]),
    .i_wr      (bus.mem_wr),
    .i_sb      (bus.mem_sb),
    .i_sh      (bus.mem_sh),
    .i_lb      (bus.mem_lb),
    .i_lh      (bus.mem_lh),
    .o_wrMask  (w_wrMask),
    .o_aligned (w_aligned),
    .o_rdShift (w_rdShift),
    .o_rdSize  (w_rdSize)
  );

  // Only store and sub-word load strobes make an access; a plain address
  // with no strobe is never checked for faults.
  assign w_wordIdx  = bus.mem_addr[AW+1:2];
  assign w_inRange  = (bus.mem_addr[31:AW+2] == '0);
  assign w_access   = bus.mem_wr | bus.mem_lb | bus.mem_lh;
  assign w_commit   = (r_state == ST_RUN) && bus.mem_wr && w_aligned && w_inRange;
  assign w_faultNow = (r_state == ST_RUN) && w_access && !r_fault &&
                      (!w_inRange || !w_aligned);

  // Sub-word store data is replicated across lanes so the mask alone picks it.
  assign w_wrLanes = bus.mem_sb ? {4{bus.mem_write_data[7:0]}} :
                     bus.mem_sh ? {2{bus.mem_write_data[15:0]}} :
                                  bus.mem_write_data;

  // Word array: zeroed one word per cycle during CLEAR, masked stores in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clearPtr] <= '0;
      end else if (w_commit) begin
        for (int i = 0; i < 4; i++) begin
          if (w_wrMask[i]) begin
            r_mem[w_wordIdx][i*8 +: 8] <= w_wrLanes[i*8 +: 8];
          end
        end
      end
    end
  end

  // Combinational load path; reads the pre-edge contents, so a store to the
  // same word becomes visible only in the following cycle.
  assign w_memWord = r_mem[w_wordIdx];
  assign w_shifted = w_memWord >> w_rdShift;

  always_comb begin
    bus.mem_read_data = '0;
    if ((r_state == ST_RUN) && w_inRange) begin
      case (w_rdSize)
        SZ_BYTE: bus.mem_read_data = {24'b0, w_shifted[7:0]};
        SZ_HALF: bus.mem_read_data = {16'b0, w_shifted[15:0]};
        default: bus.mem_read_data = w_memWord;
      endcase
    end
  end

  // Control FSM with the fault latch and store counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_clearPtr   <= '0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_faultCode  <= FAULT_NONE;
      r_faultAddr  <= '0;
      r_storeCount <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clearPtr <= r_clearPtr + 1'b1;
          if (r_clearPtr == AW'(MEM_WORDS - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_faultNow) begin
            r_fault     <= 1'b1;
            r_faultCode <= w_inRange ? FAULT_MISALIGN : FAULT_RANGE;
            r_faultAddr <= bus.mem_addr;
          end
          if (w_commit && (r_storeCount != '1)) begin
            r_storeCount <= r_storeCount + 1'b1;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign bus.fault       = r_fault;
  assign bus.fault_code  = r_faultCode;
  assign bus.fault_addr  = r_faultAddr;
  assign bus.store_count = r_storeCount;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder: the far end of the CPU datapath's load/store port (mem_addr, mem_write_data, mem_wr, mem_sb/sh/lb/lh in; mem_read_data out).
- Byte-addressable, big-endian word array with synchronous sub-word writes and same-cycle (combinational) reads, so the MEM/WB register captures read data at the same edge.
- A post-reset clear FSM, sticky fault capture and a saturating store counter provide the sequential behaviour.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; must be a power of two.
- CNT_W, 16, width of the store counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address from the EX/MEM stage.
- mem_write_data  in  32  store data, right-justified for sb/sh.
- mem_wr  in  1  store request this cycle.
- mem_sb  in  1  store byte; qualifies mem_wr.
- mem_sh  in  1  store half; qualifies mem_wr.
- mem_lb  in  1  load byte.
- mem_lh  in  1  load half.
- mem_read_data  out  32  load data, right-justified, zero-extended; sign extension belongs to write-back.
- ready  out  1  high once the memory clear has finished.
- fault  out  1  sticky fault flag.
- fault_code  out  2  first fault seen: 01 misaligned, 10 out of range, 00 none.
- fault_addr  out  32  mem_addr of the first fault.
- store_count  out  CNT_W  accepted stores, saturating.

Behaviour:
- Reset, sampled at posedge: FSM goes to CLEAR, clear_ptr=0, ready=0, fault=0, fault_code=0, fault_addr=0, store_count=0. A reset asserted in any state, including mid-CLEAR, restarts CLEAR from pointer 0.
- CLEAR: each cycle writes word[clear_ptr]=0 and increments clear_ptr. After the write of MEM_WORDS-1 the FSM goes to RUN, so ready rises exactly MEM_WORDS cycles after reset deasserts. During CLEAR all CPU stores are ignored and not counted, mem_read_data=0, and no faults are recorded.
- RUN: ready=1; the FSM stays in RUN until reset.
- Addressing: word index = mem_addr[log2(MEM_WORDS)+1:2]. The access is in range iff mem_addr < 4*MEM_WORDS.
- Byte lanes (big-endian): addr[1:0]=00 -> bits 31:24 … 11 -> bits 7:0. Halfword: addr[1]=0 -> bits 31:16, addr[1]=1 -> bits 15:0.
- Store size priority: sb > sh > word.
- Store alignment: sb always aligned; sh needs addr[0]=0; word needs addr[1:0]=00.
- Store commit: at the posedge, only when state=RUN, mem_wr=1, the access is aligned and the access is in range. Only the selected lanes are written, taken from the low bits of mem_write_data. store_count then increments, holding at all-ones.
- Load, combinational:
  - Size priority: lb > lh > word.
  - lb returns {24'b0, selected byte}; lh returns {16'b0, selected half}; otherwise the full word.
  - A misaligned load uses the address aligned down to its size (word/half) and still returns data.
  - An out-of-range load returns 0.
- Read-during-write to the same word returns the pre-write contents; the new data is visible the following cycle.
- Faults (RUN only):
  - Checked for any load (lb/lh asserted, or mem_wr=0 with a nonzero address is NOT a load; only mem_wr, mem_lb, mem_lh qualify an access).
  - Misaligned or out-of-range qualified access: if fault=0, set fault=1 and latch fault_code and fault_addr at the edge. Later faults do not overwrite.
  - Out of range takes precedence over misaligned.
  - A faulting store writes nothing and is not counted.
- No stall output: every access completes in the cycle it is presented, matching the pipeline's MEM stage timing.

Decomposition:
- Shared package holds: FSM state encoding (CLEAR, RUN), fault code constants (FAULT_NONE=00, FAULT_MISALIGN=01, FAULT_RANGE=10), and the size-select encoding (SZ_BYTE, SZ_HALF, SZ_WORD).
- One natural sub-module, lane_select: combinational. Inputs: addr[1:0], sb, sh, lb, lh. Outputs: 4-bit write lane mask, aligned flag, and read extract shift amount.
- The array, FSM, fault and counter logic remain in data_mem_responder.

Test Plan:
- Reset then idle: ready=0 for exactly MEM_WORDS cycles, then 1; reads of 0x0 and 0xFFC return 0. A store issued during CLEAR leaves memory 0 and store_count=0.
- Word store 0xDEADBEEF @0x10, then lb @0x10/0x11/0x12/0x13 -> 0xDE/0xAD/0xBE/0xEF. lh @0x12 -> 0x0000BEEF. store_count=1.
- sb 0x77 @0x11 over the 0xDEADBEEF word -> word read 0xDE77BEEF. sh 0x1234 @0x12 -> 0xDE771234. Same-cycle read during the sh returns 0xDE77BEEF.
- Word store @0x22 -> no write, fault=1, fault_code=01, fault_addr=0x22. A later out-of-range store @0x1000 leaves the code at 01. store_count is unchanged by both.
- Load @0x1000 (MEM_WORDS=1024) after fresh reset -> mem_read_data=0, fault_code=10, fault_addr=0x1000.
- Assert reset for 1 cycle midway through CLEAR and again after stores in RUN. Each time: ready drops, the full clear replays, prior data reads 0, and fault and store_count return to 0.
